// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared types and helpers for the 1-D CNN classifier datapath
package cnn1d_pkg;

   // Sequencing states of the argmax classifier stage
   typedef enum logic [1:0] {
      ARGMAX_IDLE,
      ARGMAX_SCAN,
      ARGMAX_DONE
   } argmax_state_t;

   // Ceiling log2; returns 0 for values of 0 or 1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Width of an index into a table of n entries, never narrower than one bit
   function automatic int idx_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage : cnn1d_pkg

// File: rtl/neuron_argmax.sv
// rtl/neuron_argmax.sv - sequential signed argmax over one neuron-layer output vector (optional ARGMAX_MARGIN_EN)
module neuron_argmax
   import cnn1d_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_NEURONS = 32,
   parameter int FRACTION    = 24,
   localparam int IDX_W      = idx_width(NUM_NEURONS)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  argmax_ready_in,
   input  logic [NUM_NEURONS-1:0] argmax_valid_in,
   input  logic [DATA_WIDTH-1:0] argmax_data_in [0:NUM_NEURONS-1],
   input  logic                  argmax_ready_out,
   output logic                  argmax_valid_out,
   output logic [IDX_W-1:0]      argmax_index_out,
`ifdef ARGMAX_MARGIN_EN
   output logic [DATA_WIDTH-1:0] argmax_margin_out,
`endif
   output logic [DATA_WIDTH-1:0] argmax_data_out
);

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_NEURONS - 1);
   localparam logic [IDX_W-1:0]      ONE_IDX  = IDX_W'(1);
   localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Parameter sanity: the fraction point must lie inside the word, and there must be a class
   if (FRACTION < 0 || FRACTION >= DATA_WIDTH) begin : g_bad_fraction
      $error("neuron_argmax: FRACTION must be in [0, DATA_WIDTH)");
   end
   if (NUM_NEURONS < 1) begin : g_bad_count
      $error("neuron_argmax: NUM_NEURONS must be at least 1");
   end

   argmax_state_t          state_q, state_d;
   logic                   ready_q, ready_d;
   logic                   valid_q, valid_d;
   logic [IDX_W-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  cap_q [0:NUM_NEURONS-1];
   logic [DATA_WIDTH-1:0]  cap_d [0:NUM_NEURONS-1];
   logic [DATA_WIDTH-1:0]  best_q, best_d;
   logic [IDX_W-1:0]       best_idx_q, best_idx_d;
   logic [IDX_W-1:0]       index_q, index_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
`ifdef ARGMAX_MARGIN_EN
   logic [DATA_WIDTH-1:0]  second_q, second_d;
   logic [DATA_WIDTH-1:0]  margin_q, margin_d;
   logic [DATA_WIDTH:0]    margin_diff;
`endif

   logic                   accept;
   logic [DATA_WIDTH-1:0]  cur;

   assign accept = ready_q && (&argmax_valid_in);
   assign cur    = cap_q[cnt_q];

   // Next-state, capture, running compare and result latch
   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      cap_d      = cap_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      index_d    = index_q;
      data_d     = data_q;
`ifdef ARGMAX_MARGIN_EN
      second_d    = second_q;
      margin_d    = margin_q;
      margin_diff = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
`endif
      case (state_q)
         ARGMAX_IDLE: begin
            // ready only rises from the first edge after reset release
            ready_d = 1'b1;
            if (accept) begin
               cap_d      = argmax_data_in;
               best_d     = argmax_data_in[0];
               best_idx_d = '0;
               cnt_d      = ONE_IDX;
               ready_d    = 1'b0;
`ifdef ARGMAX_MARGIN_EN
               second_d   = MIN_NEG;
`endif
               state_d    = (NUM_NEURONS == 1) ? ARGMAX_DONE : ARGMAX_SCAN;
            end
         end
         ARGMAX_SCAN: begin
            // strict compare: an equal value never displaces a lower index
            if ($signed(cur) > $signed(best_q)) begin
               best_d     = cur;
               best_idx_d = cnt_q;
`ifdef ARGMAX_MARGIN_EN
               second_d   = best_q;
`endif
            end
`ifdef ARGMAX_MARGIN_EN
            else if ($signed(cur) > $signed(second_q)) begin
               second_d = cur;
            end
`endif
            cnt_d = cnt_q + ONE_IDX;
            if (cnt_q == LAST_IDX) begin
               state_d = ARGMAX_DONE;
            end
         end
         ARGMAX_DONE: begin
            if (!valid_q) begin
               // first DONE cycle publishes the result registers
               valid_d = 1'b1;
               index_d = best_idx_q;
               data_d  = best_q;
`ifdef ARGMAX_MARGIN_EN
               // best >= second, so the difference is non-negative; bit DW-1 set means it overflowed
               margin_d = margin_diff[DATA_WIDTH-1] ? MAX_POS : margin_diff[DATA_WIDTH-1:0];
`endif
            end else if (argmax_ready_out) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = ARGMAX_IDLE;
            end
         end
         default: begin
            state_d = ARGMAX_IDLE;
            ready_d = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ARGMAX_IDLE;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            cap_q[i] <= '0;
         end
         best_q     <= '0;
         best_idx_q <= '0;
         index_q    <= '0;
         data_q     <= '0;
`ifdef ARGMAX_MARGIN_EN
         second_q   <= '0;
         margin_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         index_q    <= index_d;
         data_q     <= data_d;
`ifdef ARGMAX_MARGIN_EN
         second_q   <= second_d;
         margin_q   <= margin_d;
`endif
      end
   end

   assign argmax_ready_in   = ready_q;
   assign argmax_valid_out  = valid_q;
   assign argmax_index_out  = index_q;
   assign argmax_data_out   = data_q;
`ifdef ARGMAX_MARGIN_EN
   assign argmax_margin_out = margin_q;
`endif

endmodule : neuron_argmax

// File: tb/tb_neuron_argmax.sv
// tb/tb_neuron_argmax.sv - directed-vector bench for neuron_argmax (N=4, 16-bit, margin under ARGMAX_MARGIN_EN)
module tb_neuron_argmax;

   localparam int DW = 16;
   localparam int NN = 4;

   logic          clk;
   logic          rst;
   logic          ready_in;
   logic [NN-1:0] valid_in;
   logic [DW-1:0] data_in [0:NN-1];
   logic          ready_out;
   logic          valid_out;
   logic [1:0]    index_out;
   logic [DW-1:0] data_out;
`ifdef ARGMAX_MARGIN_EN
   logic [DW-1:0] margin_out;
`endif

   int n_vec;
   int n_err;

   neuron_argmax #(
      .DATA_WIDTH (DW),
      .NUM_NEURONS(NN),
      .FRACTION   (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .argmax_ready_in  (ready_in),
      .argmax_valid_in  (valid_in),
      .argmax_data_in   (data_in),
      .argmax_ready_out (ready_out),
      .argmax_valid_out (valid_out),
      .argmax_index_out (index_out),
`ifdef ARGMAX_MARGIN_EN
      .argmax_margin_out(margin_out),
`endif
      .argmax_data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
      data_in[0] = a;
      data_in[1] = b;
      data_in[2] = c;
      data_in[3] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // First edge is the accepting edge; then count edges until valid_out rises
   task automatic wait_valid(input string tag, input int exp_lat);
      int n;
      tick();
      valid_in = '0;
      chk({tag, "_accept_ready"}, 32'(ready_in), 32'd0);
      n = 0;
      while (!valid_out && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
   endtask

   task automatic chk_result(input string tag, input logic [1:0] idx,
                             input logic [DW-1:0] dat, input logic [DW-1:0] mrg);
      chk({tag, "_valid"}, 32'(valid_out), 32'd1);
      chk({tag, "_index"}, 32'(index_out), 32'(idx));
      chk({tag, "_data"},  32'(data_out),  32'(dat));
`ifdef ARGMAX_MARGIN_EN
      chk({tag, "_margin"}, 32'(margin_out), 32'(mrg));
`else
      if (mrg != mrg) n_err++;
`endif
   endtask

   task automatic chk_released(input string tag);
      tick();
      chk({tag, "_valid_drop"}, 32'(valid_out), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready_in), 32'd1);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b0;
      valid_in  = '0;
      ready_out = 1'b1;
      set_vec(16'h0, 16'h0, 16'h0, 16'h0);

      // reset state
      #3;
      chk("rst_ready", 32'(ready_in), 32'd0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_index", 32'(index_out), 32'd0);
      chk("rst_data",  32'(data_out), 32'd0);
      tick();
      rst = 1'b1;
      chk("rel_ready_low", 32'(ready_in), 32'd0);
      tick();
      chk("rel_ready_high", 32'(ready_in), 32'd1);

      // 1: basic positive vector
      set_vec(16'h0100, 16'h0300, 16'hFF00, 16'h0200);
      valid_in = 4'b1111;
      wait_valid("t1", 4);
      chk_result("t1", 2'd1, 16'h0300, 16'h0100);
      chk_released("t1");

      // 2: all negative, signed compare
      set_vec(16'hFF00, 16'hFE00, 16'hFF80, 16'hFC00);
      valid_in = 4'b1111;
      wait_valid("t2", 4);
      chk_result("t2", 2'd2, 16'hFF80, 16'h0080);
      chk_released("t2");

      // 3: tie keeps the lowest index
      set_vec(16'h0200, 16'h0200, 16'h0100, 16'h0200);
      valid_in = 4'b1111;
      wait_valid("t3", 4);
      chk_result("t3", 2'd0, 16'h0200, 16'h0000);
      chk_released("t3");

      // 4: partial valid mask is ignored
      set_vec(16'h0010, 16'h0020, 16'h0030, 16'h0005);
      valid_in = 4'b1011;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_partial_ready", 32'(ready_in), 32'd1);
         chk("t4_partial_valid", 32'(valid_out), 32'd0);
      end
      valid_in = 4'b1111;
      wait_valid("t4", 4);
      chk_result("t4", 2'd2, 16'h0030, 16'h0010);
      chk_released("t4");

      // 5: downstream stall holds the result and blocks a new vector
      ready_out = 1'b0;
      set_vec(16'h0100, 16'h0080, 16'h0000, 16'h0400);
      valid_in = 4'b1111;
      wait_valid("t5a", 4);
      chk_result("t5a", 2'd3, 16'h0400, 16'h0300);
      set_vec(16'h0001, 16'hFFFF, 16'h0003, 16'h0002);
      valid_in = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_result("t5_stall", 2'd3, 16'h0400, 16'h0300);
         chk("t5_stall_ready", 32'(ready_in), 32'd0);
      end
      ready_out = 1'b1;
      chk_released("t5");
      wait_valid("t5b", 4);
      chk_result("t5b", 2'd2, 16'h0003, 16'h0001);
      chk_released("t5b");

      // 6: reset during SCAN discards the result
      set_vec(16'h0500, 16'h0600, 16'h0700, 16'h0800);
      valid_in = 4'b1111;
      tick();
      valid_in = '0;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(valid_out), 32'd0);
      chk("t6_rst_index", 32'(index_out), 32'd0);
      chk("t6_rst_data",  32'(data_out), 32'd0);
      chk("t6_rst_ready", 32'(ready_in), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("t6_rel_ready", 32'(ready_in), 32'd1);
      set_vec(16'h0000, 16'h0000, 16'h0000, 16'h7FFF);
      valid_in = 4'b1111;
      wait_valid("t6", 4);
      chk_result("t6", 2'd3, 16'h7FFF, 16'h7FFF);
      chk_released("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_neuron_argmax
